// File: rtl/rv_mem_pkg.sv
// Shared memory-side types for the data controller and byte-merge logic.
// Word/byte-enable typedefs, controller state encoding and byte-enable expansion.
package rv_mem_pkg;

    typedef logic [31:0] rvwordT;
    typedef logic [3:0]  byteenT;

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        RMW
    } dmem_state_e;

    function automatic rvwordT be_to_mask(input byteenT be);
        rvwordT mask;
        mask = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/dmem_ctrl_if.sv
// Load/store request and response bus between the core LSU (master) and dmem_ctrl (slave).
interface dmem_ctrl_if;
    import rv_mem_pkg::*;

    logic   req_valid;
    logic   req_ready;
    logic   req_we;
    rvwordT req_addr;
    byteenT req_be;
    rvwordT req_wdata;
    logic   rsp_valid;
    rvwordT rsp_rdata;
    logic   rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/dmem_byte_merge.sv
// Combinational byte-lane merge: lanes with be set take new_word, the rest keep old_word.
module dmem_byte_merge
    import rv_mem_pkg::*;
(
    input  rvwordT old_word,
    input  rvwordT new_word,
    input  byteenT be,
    output rvwordT merged
);

    rvwordT mask;

    always_comb begin
        mask   = be_to_mask(be);
        merged = (old_word & ~mask) | (new_word & mask);
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-port controller: byte-addressed loads/stores to a word-wide memory, sub-word stores via RMW.
// Define DMEM_BOUNDS_CHECK_EN to reject word indices >= 2**MEM_WIDTH with rsp_err.
module dmem_ctrl
    import rv_mem_pkg::*;
#(
    parameter int unsigned MEM_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus,
    output logic        mem_we,
    output rvwordT      mem_addr,
    output rvwordT      mem_wdata,
    input  rvwordT      mem_rdata
);

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam bit BOUNDS_CHECK = 1'b1;
`else
    localparam bit BOUNDS_CHECK = 1'b0;
`endif

    dmem_state_e state;
    logic        load_q;
    logic        err_q;
    rvwordT      addr_q;
    byteenT      be_q;
    rvwordT      wdata_q;
    rvwordT      merged_word;

    logic        accept;
    logic        in_range;
    logic        range_ok;
    logic        full_store;
    logic        partial_store;
    rvwordT      word_idx;
    logic        unused_addr_lsb;

    assign unused_addr_lsb = ^bus.req_addr[1:0];

    assign word_idx      = {2'b00, bus.req_addr[31:2]};
    assign in_range      = (bus.req_addr[31:2] >> MEM_WIDTH) == '0;
    assign range_ok      = BOUNDS_CHECK ? in_range : 1'b1;
    assign full_store    = bus.req_we && (bus.req_be == 4'hF);
    assign partial_store = bus.req_we && (bus.req_be != 4'h0) && (bus.req_be != 4'hF);

    assign bus.req_ready = !rst && (state != RMW);
    assign accept        = bus.req_valid && bus.req_ready;

    dmem_byte_merge u_merge (
        .old_word (mem_rdata),
        .new_word (wdata_q),
        .be       (be_q),
        .merged   (merged_word)
    );

    // RMW drives the held word; otherwise the port follows the incoming request.
    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = word_idx;
        mem_wdata = bus.req_wdata;
        if (state == RMW) begin
            mem_we    = !rst;
            mem_addr  = addr_q;
            mem_wdata = merged_word;
        end else begin
            mem_we = accept && full_store && range_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                RMW: begin
                    state  <= RESP;
                    load_q <= 1'b0;
                    err_q  <= 1'b0;
                end
                default: begin
                    if (accept) begin
                        load_q  <= !bus.req_we && range_ok;
                        err_q   <= !range_ok;
                        addr_q  <= word_idx;
                        be_q    <= bus.req_be;
                        wdata_q <= bus.req_wdata;
                        state   <= (partial_store && range_ok) ? RMW : RESP;
                    end else begin
                        load_q <= 1'b0;
                        err_q  <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    // Load data comes straight from the memory the cycle after the address was presented.
    assign bus.rsp_valid = !rst && (state == RESP);
    assign bus.rsp_rdata = (bus.rsp_valid && load_q) ? mem_rdata : '0;
    assign bus.rsp_err   = bus.rsp_valid && err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl against a small synchronous word-memory model.
module tb_dmem_ctrl;
    import rv_mem_pkg::*;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   init_mem = 1'b1;
    logic   mem_we;
    rvwordT mem_addr;
    rvwordT mem_wdata;
    rvwordT mem_rdata;
    rvwordT mem [64];

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    dmem_ctrl_if bus ();

    dmem_ctrl #(.MEM_WIDTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Read-first synchronous memory; a write lands at the edge ending its write cycle.
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h1;
            mem[1] <= 32'h2;
            mem[2] <= 32'h3;
            mem[8] <= 32'h55AA55AA;
            mem[9] <= 32'h0000BEEF;
        end else if (mem_we) begin
            mem[mem_addr[5:0]] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr[5:0]];
    end

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        acc_we;
        logic        rmw;
        logic [31:0] merge;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs [12];

    function automatic vec_t mk(input logic we, input logic [31:0] addr, input logic [3:0] be,
                                input logic [31:0] wdata, input logic acc_we, input logic rmw,
                                input logic [31:0] merge, input logic [31:0] rdata, input logic err);
        vec_t v;
        v.we = we; v.addr = addr; v.be = be; v.wdata = wdata; v.acc_we = acc_we;
        v.rmw = rmw; v.merge = merge; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h0;
        bus.req_be    = 4'h0;
        bus.req_wdata = 32'h0;
    endtask

    task automatic drive(input logic we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wdata);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_be    = be;
        bus.req_wdata = wdata;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered 1 time unit after a posedge with the controller idle.
    task automatic apply(input vec_t v, input string tag);
        drive(v.we, v.addr, v.be, v.wdata);
        @(negedge clk);
        chk({tag, " ready"}, bus.req_ready, 32'h1);
        chk({tag, " acc_we"}, mem_we, v.acc_we);
        chk({tag, " acc_addr"}, mem_addr, {2'b00, v.addr[31:2]});
        if (v.acc_we) chk({tag, " acc_wdata"}, mem_wdata, v.wdata);
        step();
        idle_inputs();
        if (v.rmw) begin
            @(negedge clk);
            chk({tag, " rmw_ready"}, bus.req_ready, 32'h0);
            chk({tag, " rmw_we"}, mem_we, 32'h1);
            chk({tag, " rmw_addr"}, mem_addr, {2'b00, v.addr[31:2]});
            chk({tag, " rmw_wdata"}, mem_wdata, v.merge);
            step();
        end
        @(negedge clk);
        chk({tag, " rsp_valid"}, bus.rsp_valid, 32'h1);
        chk({tag, " rsp_rdata"}, bus.rsp_rdata, v.rdata);
        chk({tag, " rsp_err"}, bus.rsp_err, v.err);
        chk({tag, " rsp_we"}, mem_we, 32'h0);
        step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t rb;
        vecs[0]  = mk(1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        vecs[1]  = mk(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
        vecs[2]  = mk(1'b1, 32'h10, 4'h2, 32'h0000AB00, 1'b0, 1'b1, 32'hDEADABEF, 32'h0, 1'b0);
        vecs[3]  = mk(1'b0, 32'h10, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'hDEADABEF, 1'b0);
        vecs[4]  = mk(1'b1, 32'h20, 4'h0, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        vecs[5]  = mk(1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h55AA55AA, 1'b0);
        vecs[6]  = mk(1'b1, 32'h20, 4'h9, 32'h11000022, 1'b0, 1'b1, 32'h11AA5522, 32'h0, 1'b0);
        vecs[7]  = mk(1'b0, 32'h20, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h11AA5522, 1'b0);
        vecs[8]  = mk(1'b1, 32'h24, 4'hC, 32'hCAFE0000, 1'b0, 1'b1, 32'hCAFEBEEF, 32'h0, 1'b0);
        vecs[9]  = mk(1'b0, 32'h24, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'hCAFEBEEF, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
        vecs[10] = mk(1'b0, 32'h0004_0000, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
        vecs[11] = mk(1'b1, 32'h0004_0000, 4'h2, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
`else
        // Model aliases word 0x10000 onto word 0, which holds 1.
        vecs[10] = mk(1'b0, 32'h0004_0000, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h1, 1'b0);
        vecs[11] = mk(1'b1, 32'h0004_0000, 4'h2, 32'h0, 1'b0, 1'b1, 32'h1, 32'h0, 1'b0);
`endif

        idle_inputs();

        // Reset held for two cycles.
        @(negedge clk);
        chk("rst0 ready", bus.req_ready, 32'h0);
        chk("rst0 rsp_valid", bus.rsp_valid, 32'h0);
        chk("rst0 mem_we", mem_we, 32'h0);
        @(negedge clk);
        chk("rst1 ready", bus.req_ready, 32'h0);
        chk("rst1 rsp_valid", bus.rsp_valid, 32'h0);
        step();
        rst = 1'b0;
        init_mem = 1'b0;
        @(negedge clk);
        chk("post_rst ready", bus.req_ready, 32'h1);
        chk("post_rst rsp_valid", bus.rsp_valid, 32'h0);
        chk("post_rst mem_we", mem_we, 32'h0);
        step();

        for (int i = 0; i < 12; i++) apply(vecs[i], $sformatf("v%0d", i));

        // Back-to-back loads, each accepted during the previous response.
        drive(1'b0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("b2b ready0", bus.req_ready, 32'h1);
        step();
        drive(1'b0, 32'h4, 4'h0, 32'h0);
        @(negedge clk);
        chk("b2b ready1", bus.req_ready, 32'h1);
        chk("b2b valid0", bus.rsp_valid, 32'h1);
        chk("b2b rdata0", bus.rsp_rdata, 32'h1);
        step();
        drive(1'b0, 32'h8, 4'h0, 32'h0);
        @(negedge clk);
        chk("b2b valid1", bus.rsp_valid, 32'h1);
        chk("b2b rdata1", bus.rsp_rdata, 32'h2);
        step();
        idle_inputs();
        @(negedge clk);
        chk("b2b valid2", bus.rsp_valid, 32'h1);
        chk("b2b rdata2", bus.rsp_rdata, 32'h3);
        step();
        @(negedge clk);
        chk("b2b idle", bus.rsp_valid, 32'h0);
        step();

        // Full store followed by a load of the same word during its response.
        drive(1'b1, 32'h2C, 4'hF, 32'h77778888);
        step();
        drive(1'b0, 32'h2C, 4'h0, 32'h0);
        @(negedge clk);
        chk("raw store_rsp", bus.rsp_valid, 32'h1);
        chk("raw store_rdata", bus.rsp_rdata, 32'h0);
        step();
        idle_inputs();
        @(negedge clk);
        chk("raw load_valid", bus.rsp_valid, 32'h1);
        chk("raw load_rdata", bus.rsp_rdata, 32'h77778888);
        step();

        // Reset asserted in the RMW cycle abandons the merge write.
        drive(1'b1, 32'h0, 4'h1, 32'h000000FF);
        step();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        chk("rmw_rst mem_we", mem_we, 32'h0);
        chk("rmw_rst rsp_valid", bus.rsp_valid, 32'h0);
        chk("rmw_rst ready", bus.req_ready, 32'h0);
        step();
        @(negedge clk);
        chk("rmw_rst rsp_valid2", bus.rsp_valid, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rmw_rst after_valid", bus.rsp_valid, 32'h0);
        chk("rmw_rst after_ready", bus.req_ready, 32'h1);
        step();
        rb = mk(1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h1, 1'b0);
        apply(rb, "rmw_rst readback");

        // Reset during RESP suppresses the response.
        drive(1'b0, 32'h8, 4'h0, 32'h0);
        step();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        chk("resp_rst rsp_valid", bus.rsp_valid, 32'h0);
        chk("resp_rst rsp_rdata", bus.rsp_rdata, 32'h0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("resp_rst after", bus.rsp_valid, 32'h0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
